// File: rtl/counter_pkg.sv
// Shared definitions for the counter labs: controller state encoding and
// the default counter width.
package counter_pkg;

  localparam int unsigned COUNTER_WIDTH_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } ctrl_state_t;

endpackage : counter_pkg

// File: rtl/counter_dp.sv
// Counter datapath: WIDTH-bit count register with synchronous load and
// increment enable, plus an early compare of the incremented value against
// the captured terminal value so the controller can finish on the same edge.
module counter_dp
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = COUNTER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] target_i,
  output logic [WIDTH-1:0] q_o,
  output logic             eq_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_inc;

  // Incremented value wraps naturally at 2^WIDTH.
  assign count_inc = count_q + WIDTH'(1);
  assign eq_o      = (count_inc == target_i);
  assign q_o       = count_q;

  // Next count: load has priority over increment, otherwise hold.
  always_comb begin
    // NOTE: assigning the hold value first means every path drives count_d, so no latch is inferred.
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = count_inc;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : counter_dp

// File: rtl/counter_ctrl.sv
// Sequencing controller for a bounded count window: captures start/terminal
// values, counts once per un-paused cycle, and holds done until acknowledged.
// Optional auto-reload restarts the window on ack instead of going idle.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = COUNTER_WIDTH_DEFAULT,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] target,
  input  logic             pause,
  input  logic             ack,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  ctrl_state_t      state_q, state_d;
  logic [WIDTH-1:0] load_val_q, load_val_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             dp_load;
  logic [WIDTH-1:0] dp_load_val;
  logic             dp_inc;
  logic             dp_eq;
  logic             capture;

  counter_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk        (clk),
    .rst        (rst),
    .load_i     (dp_load),
    .load_val_i (dp_load_val),
    .inc_i      (dp_inc),
    .target_i   (target_q),
    .q_o        (q),
    .eq_o       (dp_eq)
  );

  // Next-state and datapath control decode.
  always_comb begin
    state_d     = state_q;
    dp_load     = 1'b0;
    dp_load_val = load_val_q;
    dp_inc      = 1'b0;
    capture     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          capture     = 1'b1;
          dp_load     = 1'b1;
          dp_load_val = load_val;
          state_d     = (load_val == target) ? DONE : RUN;
        end
      end
      RUN: begin
        if (pause) begin
          state_d = HOLD;
        end else begin
          dp_inc = 1'b1;
          if (dp_eq) state_d = DONE;
        end
      end
      HOLD: begin
        // Leaving HOLD costs one edge with no increment.
        if (!pause) state_d = RUN;
      end
      DONE: begin
        // A start arriving with ack is dropped here; it is seen again in IDLE.
        if (ack) begin
          if (AUTO_RELOAD) begin
            dp_load = 1'b1;
            state_d = (load_val_q == target_q) ? DONE : RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture values only on an accepted start; outputs decode the next state
  // so they are registered alongside it.
  always_comb begin
    load_val_d = capture ? load_val : load_val_q;
    target_d   = capture ? target   : target_q;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  // State, capture and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      load_val_q <= '0;
      target_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_val_q <= load_val_d;
      target_q   <= target_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule : counter_ctrl
